// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SRL   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_EQ    = 4'b1000,
    OP_NE    = 4'b1001,
    OP_SLT   = 4'b1010,
    OP_SLTU  = 4'b1011,
    OP_MUL   = 4'b1100,
    OP_MULHU = 4'b1101,
    OP_DIVU  = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic logic is_multicycle(alu_op_e op);
    return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  endfunction

  function automatic logic is_divide(alu_op_e op);
    return op inside {OP_DIVU, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared iterative engine: unsigned shift-add multiply or restoring divide,
// one step per clock for DATA_WIDTH clocks after start.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    start,
  input  logic                    mode_div,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] prod,
  output logic [DATA_WIDTH-1:0]   quot,
  output logic [DATA_WIDTH-1:0]   rem
);

  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

  logic [CW-1:0]           count;
  logic                    mode_q;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH:0]     rem_q;
  logic [DATA_WIDTH-1:0]   quot_q;

  logic [DATA_WIDTH:0]     sum;
  logic [2*DATA_WIDTH-1:0] acc_nxt;
  logic [DATA_WIDTH:0]     shifted;
  logic                    ge;
  logic [DATA_WIDTH:0]     rem_nxt;
  logic [DATA_WIDTH-1:0]   quot_nxt;

  // Multiplier sits in acc's low half and is consumed LSB-first as acc shifts right.
  always_comb begin
    sum      = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
    acc_nxt  = {sum, acc[DATA_WIDTH-1:1]};
    shifted  = {rem_q[DATA_WIDTH-1:0], quot_q[DATA_WIDTH-1]};
    ge       = (shifted >= {1'b0, mcand});
    rem_nxt  = ge ? (shifted - {1'b0, mcand}) : shifted;
    quot_nxt = {quot_q[DATA_WIDTH-2:0], ge};
  end

  // Outputs expose the result of the step being taken this cycle so the
  // caller can register the final answer on the same edge.
  assign done = (count == CW'(1));
  assign prod = acc_nxt;
  assign quot = quot_nxt;
  assign rem  = rem_nxt[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      mode_q <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      rem_q  <= '0;
      quot_q <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (start) begin
      count  <= CW'(DATA_WIDTH);
      mode_q <= mode_div;
      mcand  <= mode_div ? op_b : op_a;
      acc    <= {{DATA_WIDTH{1'b0}}, op_b};
      rem_q  <= '0;
      quot_q <= op_a;
    end else if (count != '0) begin
      count <= count - CW'(1);
      if (mode_q) begin
        rem_q  <= rem_nxt;
        quot_q <= quot_nxt;
      end else begin
        acc <= acc_nxt;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU behind valid/ready handshakes; single-cycle
// ops inline, MUL/MULHU/DIVU/REMU through the shared iterative engine.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  state_e                    state_q, state_d;
  alu_op_e                   op_in, op_q;
  logic [DATA_WIDTH-1:0]     result_q, result_d, single_res;
  logic [SHW-1:0]            shamt;
  logic                      accept, start, op_div, div_zero;
  logic                      eng_done;
  logic [2*DATA_WIDTH-1:0]   eng_prod;
  logic [DATA_WIDTH-1:0]     eng_quot, eng_rem;

  assign op_in    = alu_op_e'(Operation);
  assign shamt    = SrcB[SHW-1:0];
  assign op_div   = is_divide(op_in);
  assign div_zero = op_div && (SrcB == '0);
  assign accept   = in_valid && (state_q == IDLE);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign ALUResult = result_q;

  // Divide-by-zero answers are produced here so they bypass the engine.
  always_comb begin
    single_res = '0;
    unique case (op_in)
      OP_AND:   single_res = SrcA & SrcB;
      OP_OR:    single_res = SrcA | SrcB;
      OP_ADD:   single_res = SrcA + SrcB;
      OP_SUB:   single_res = SrcA - SrcB;
      OP_XOR:   single_res = SrcA ^ SrcB;
      OP_SLL:   single_res = SrcA << shamt;
      OP_SRL:   single_res = SrcA >> shamt;
      OP_SRA:   single_res = $signed(SrcA) >>> shamt;
      OP_EQ:    single_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_NE:    single_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
      OP_SLT:   single_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU:  single_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_MUL:   single_res = '0;
      OP_MULHU: single_res = '0;
      OP_DIVU:  single_res = '1;
      OP_REMU:  single_res = SrcA;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_multicycle(op_in) && !div_zero) begin
            start   = 1'b1;
            state_d = BUSY;
          end else begin
            result_d = single_res;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        if (eng_done) begin
          unique case (op_q)
            OP_MULHU: result_d = eng_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIVU:  result_d = eng_quot;
            OP_REMU:  result_d = eng_rem;
            default:  result_d = eng_prod[DATA_WIDTH-1:0];
          endcase
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
      start    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      op_q     <= OP_AND;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (start) op_q <= op_in;
    end
  end

  alu_iter_muldiv #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .start    (start),
    .mode_div (op_div),
    .op_a     (SrcA),
    .op_b     (SrcB),
    .done     (eng_done),
    .prod     (eng_prod),
    .quot     (eng_quot),
    .rem      (eng_rem)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver queues expected results from a
// plain-arithmetic model; a negedge monitor checks each transfer.
module tb_alu_mc;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] src_a = '0;
  logic [DW-1:0] src_b = '0;
  logic [3:0]    op = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_result;
  logic          busy;

  logic rand_ready = 1'b0;
  logic dir_ready  = 1'b1;
  logic rnd_bit    = 1'b1;
  assign out_ready = rand_ready ? rnd_bit : dir_ready;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [DW-1:0] exp;
    int            lat;
    int            acc_cyc;
    logic [3:0]    op;
  } exp_t;
  exp_t sb[$];

  alu_mc #(
    .DATA_WIDTH(DW),
    .OPCODE_LENGTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (src_a),
    .SrcB      (src_b),
    .Operation (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (alu_result),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0]   p;
    logic signed [DW-1:0] sa;
    int                sh;
    p  = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    sa = a;
    sh = int'(b % DW);
    case (o)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return sa >>> sh;
      4'd8:  return (a == b) ? 1 : 0;
      4'd9:  return (a != b) ? 1 : 0;
      4'd10: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd11: return (a < b) ? 1 : 0;
      4'd12: return p[DW-1:0];
      4'd13: return p[2*DW-1:DW];
      4'd14: return (b == 0) ? {DW{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Latency = clock edges after the accept edge until out_valid is seen.
  function automatic int model_lat(input logic [3:0] o, input logic [DW-1:0] b);
    if (o >= 4'd14 && b == 0) return 0;
    return (o >= 4'd12) ? DW : 0;
  endfunction

  bit seen = 1'b0;
  int vcyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        vcyc = cyc;
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", {31'b0, out_valid}, '0);
        end else begin
          e = sb.pop_front();
          check($sformatf("result_op%0d", e.op), alu_result, e.exp);
          check($sformatf("latency_op%0d", e.op), vcyc - e.acc_cyc, e.lat);
        end
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit expect_out);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 1);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (expect_out) begin
      e.exp = model(o, a, b);
      e.lat = model_lat(o, b);
      e.acc_cyc = cyc;
      e.op = o;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] held;
    logic [DW-1:0] ra, rb;
    logic [3:0]    ro;
    int            n;
    int            vcount;

    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 1);
    check("reset_out_valid", {31'b0, out_valid}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_result", alu_result, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(4'd2, 32'hFFFF_FFFF, 32'h1, 1);
    issue(4'd3, 32'h0, 32'h1, 1);
    issue(4'd7, 32'h8000_0000, 32'h24, 1);
    issue(4'd10, 32'hFFFF_FFFF, 32'h1, 1);
    issue(4'd11, 32'hFFFF_FFFF, 32'h1, 1);
    issue(4'd8, 32'h5, 32'h5, 1);
    issue(4'd12, 32'h0001_0000, 32'h0001_0000, 1);
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      check($sformatf("mul_busy_c%0d", i), {31'b0, busy}, 1);
      check($sformatf("mul_in_ready_c%0d", i), {31'b0, in_ready}, 0);
    end
    issue(4'd13, 32'h0001_0000, 32'h0001_0000, 1);
    issue(4'd14, 32'd100, 32'd7, 1);
    issue(4'd15, 32'd100, 32'd7, 1);
    issue(4'd14, 32'h1234, 32'h0, 1);
    issue(4'd15, 32'h1234, 32'h0, 1);
    drain();

    // Backpressure: result must hold while out_ready is low.
    dir_ready = 1'b0;
    issue(4'd1, 32'hA5A5_0000, 32'h0000_5A5A, 1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    held = alu_result;
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", {31'b0, out_valid}, 1);
      check("hold_result", alu_result, held);
      check("hold_in_ready", {31'b0, in_ready}, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 dir_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_transfer_in_ready", {31'b0, in_ready}, 1);
    check("post_transfer_out_valid", {31'b0, out_valid}, 0);
    drain();

    // Flush mid-divide drops the op.
    issue(4'd14, 32'd1000, 32'd3, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_in_ready", {31'b0, in_ready}, 1);
    check("flush_busy", {31'b0, busy}, 0);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("flush_no_out_valid", vcount, 0);
    issue(4'd2, 32'd2, 32'd3, 1);
    drain();

    // Flush on the accept edge wins.
    @(negedge clk);
    op = 4'd2; src_a = 32'd9; src_b = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_out_valid", {31'b0, out_valid}, 0);
    check("flush_accept_in_ready", {31'b0, in_ready}, 1);

    // Async reset mid-divide.
    issue(4'd15, 32'd1000, 32'd3, 0);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_result", alu_result, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(4'd2, 32'd2, 32'd3, 1);
    drain();

    // Randomised traffic with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = DW'($urandom_range(1, 64));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) rb = ra;
      issue(ro, ra, rb, 1);
    end
    drain();
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the datapath's combinational ALU.
- Keeps the existing 4-bit operation encodings and adds shifts, signed and unsigned compares, iterative multiply and iterative unsigned divide/remainder.
- Sits in the execute stage behind a valid/ready handshake, so the pipeline control stalls on multi-cycle ops.
- Single-cycle ops return in 1 cycle; MUL/MULHU/DIVU/REMU return in DATA_WIDTH cycles.

Parameters:
- DATA_WIDTH, 32: operand/result width; power of two, >= 8.
- OPCODE_LENGTH, 4: Operation width; fixed at 4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous abort of any in-flight or held operation.
- in_valid  in  1  operands/Operation valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- SrcA  in  DATA_WIDTH  operand A.
- SrcB  in  DATA_WIDTH  operand B.
- Operation  in  OPCODE_LENGTH  op select.
- out_valid  out  1  ALUResult valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- ALUResult  out  DATA_WIDTH  registered result.
- busy  out  1  high in BUSY.

Behaviour:
- Clocking and reset (decided): one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, ALUResult=0, counter=0, internal operand/accumulator registers=0.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR (all wrap modulo 2^DATA_WIDTH).
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount = SrcB[$clog2(DATA_WIDTH)-1:0].
  - 1000 EQ, 1001 NE, 1010 SLT (signed), 1011 SLTU; compare results are zero-extended 1 or 0.
  - 1100 MUL (low DATA_WIDTH bits), 1101 MULHU (high DATA_WIDTH bits of unsigned product).
  - 1110 DIVU, 1111 REMU.
  - No undefined codes remain.
- Handshake:
  - Accept occurs when in_valid && in_ready at a clock edge.
  - Result transfer occurs when out_valid && out_ready at a clock edge.
  - In DONE, ALUResult and out_valid are held stable until transfer.
  - No new accept while in BUSY or DONE.
- FSM:
  - IDLE -> DONE on accept of a single-cycle op; the result is computed and registered on the accept edge, so latency is 1.
  - IDLE -> BUSY on accept of MUL/MULHU/DIVU/REMU. Operands are latched and the counter is loaded with DATA_WIDTH.
  - BUSY: one iteration per edge, counter decrements. When counter==1, that edge performs the final step, writes ALUResult and goes to DONE. Latency from accept edge to out_valid is DATA_WIDTH cycles.
  - DONE -> IDLE on transfer. in_ready rises the cycle after transfer (one idle bubble is accepted by design).
- Multiply: shift-add on a 2*DATA_WIDTH accumulator, examining multiplier LSB each step, unsigned. MUL returns the low half, MULHU the high half.
- Divide: restoring, one quotient bit per step, with a DATA_WIDTH+1-bit partial remainder.
- Divide by zero (SrcB==0): no iterations; IDLE -> DONE directly with latency 1. DIVU returns all ones; REMU returns SrcA.
- flush: highest synchronous priority. In any state, next state is IDLE, out_valid=0, counter=0; ALUResult is retained. A flush coinciding with an accept or transfer wins: the op is dropped.
- rst_n low mid-operation: immediately returns to reset values with no partial result.
- busy = (state==BUSY); in_ready = (state==IDLE).

Decomposition:
- Package alu_pkg holds:
  - alu_op_e enum with the 16 opcodes above.
  - state_e {IDLE, BUSY, DONE}.
  - Function is_multicycle(alu_op_e).
- Sub-module alu_iter_muldiv holds the shared iterative engine: counter, accumulator, remainder and quotient registers; start/done interface; one mode bit mul/div.
- Single-cycle ops remain inline in alu_mc.

Test Plan (DATA_WIDTH=32):
- Reset then ADD SrcA=0xFFFFFFFF, SrcB=1 -> out_valid 1 cycle after accept, ALUResult=0x00000000. SUB 0 - 1 -> 0xFFFFFFFF.
- SRA SrcA=0x80000000, SrcB=0x00000024 (shamt 4) -> 0xF8000000. SLT 0xFFFFFFFF vs 1 -> 1. SLTU same operands -> 0. EQ 5,5 -> 1.
- MUL 0x00010000 * 0x00010000 -> out_valid exactly 32 cycles after accept, ALUResult=0. MULHU same operands -> 0x00000001. in_ready=0 and busy=1 throughout.
- DIVU 100/7 -> 14; REMU 100/7 -> 2, latency 32. DIVU 0x1234/0 -> 0xFFFFFFFF at latency 1; REMU 0x1234/0 -> 0x1234.
- out_ready held low 5 cycles in DONE -> ALUResult and out_valid stable. Transfer on the cycle out_ready=1, then in_ready=1 on the following cycle.
- flush at cycle 10 of a DIVU, and a separate test asserting rst_n low at cycle 10 -> IDLE next edge (immediately for reset), out_valid never asserts for that op. The next ADD 2+3 -> 5 with latency 1.
